// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, reply tags,
// FSM state encoding and a helper that builds the error reply word.
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_STATUS  = 8'h03;

    localparam logic [7:0] TAG_WR_ACK = 8'hA1;
    localparam logic [7:0] TAG_ERR    = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WR_PAYLOAD = 2'd1,
        ST_RD_DUMMY   = 2'd2
    } state_e;

    // Reply for a rejected command: error tag, opcode echoed in the low byte.
    function automatic logic [63:0] err_reply(input logic [7:0] opcode);
        return {TAG_ERR, 48'd0, opcode};
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_edge.sv
// Rising-edge strobe for the SPI word receiver's "word held" level.
// A level that is already high while reset is asserted is masked until it
// has been seen low once, so a stale word never produces a strobe.
module spi_cmd_edge (
    input  logic clk,
    input  logic reset,
    input  logic word_received,
    output logic word_strobe
);

    logic word_received_q;
    logic word_received_d;
    logic block_q;
    logic block_d;

    // Next-state for the delayed level and the post-reset mask.
    always_comb begin
        word_received_d = word_received;
        block_d         = block_q & word_received;
    end

    // Edge-detect and mask registers; the mask captures the level during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_received_q <= 1'b0;
            block_q         <= word_received;
        end else begin
            word_received_q <= word_received_d;
            block_q         <= block_d;
        end
    end

    assign word_strobe = word_received & ~word_received_q & ~block_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: decodes 64-bit command words from an SPI word
// receiver, maintains a 64-bit configuration register file and produces
// reply words for the SPI transmitter.
// Optional feature: define CMD_ERR_COUNT_EN to implement a saturating
// 16-bit rejected-command counter reported by STATUS.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter logic [7:0]  VERSION  = 8'h01
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     word_received,
    input  logic [63:0]              word_data_received,
    output logic [63:0]              word_send_data,
    output logic [64*NUM_REGS-1:0]   cfg_regs,
    output logic                     cfg_wr_stb,
    output logic [7:0]               cfg_wr_addr,
    output logic                     cmd_error,
    output logic                     busy
);

    localparam logic [8:0] ADDR_LIMIT = 9'(NUM_REGS);

    logic        word_strobe;
    logic [7:0]  opcode;
    logic [7:0]  cmd_addr;
    logic        addr_ok;
    logic [63:0] rd_data;
    logic [15:0] err_field;

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [63:0] word_send_data_q, word_send_data_d;
    logic        cfg_wr_stb_q, cfg_wr_stb_d;
    logic [7:0]  cfg_wr_addr_q, cfg_wr_addr_d;
    logic        cmd_error_q, cmd_error_d;
    logic        busy_q, busy_d;
    logic        reg_wr_en;
    logic [63:0] regs_q [NUM_REGS];
    logic [63:0] regs_d [NUM_REGS];

    spi_cmd_edge u_edge (
        .clk           (clk),
        .reset         (reset),
        .word_received (word_received),
        .word_strobe   (word_strobe)
    );

    assign opcode   = word_data_received[63:56];
    assign cmd_addr = word_data_received[7:0];
    assign addr_ok  = ({1'b0, cmd_addr} < ADDR_LIMIT);

    // Register read mux; out-of-range addresses never reach the reply.
    always_comb begin
        rd_data = 64'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == 8'(i)) begin
                rd_data = regs_q[i];
            end else begin
                rd_data = rd_data;
            end
        end
    end

    // Command FSM next-state and reply/strobe outputs; acts only on a strobe.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        word_send_data_d = word_send_data_q;
        cfg_wr_stb_d     = 1'b0;
        cfg_wr_addr_d    = cfg_wr_addr_q;
        cmd_error_d      = 1'b0;
        reg_wr_en        = 1'b0;
        if (word_strobe) begin
            case (state_q)
                ST_IDLE: begin
                    case (opcode)
                        OP_NOP: begin
                            word_send_data_d = 64'd0;
                        end
                        OP_WRITE: begin
                            if (addr_ok) begin
                                addr_d           = cmd_addr;
                                state_d          = ST_WR_PAYLOAD;
                                word_send_data_d = {TAG_WR_ACK, 48'd0, cmd_addr};
                            end else begin
                                cmd_error_d      = 1'b1;
                                word_send_data_d = err_reply(opcode);
                            end
                        end
                        OP_READ: begin
                            if (addr_ok) begin
                                state_d          = ST_RD_DUMMY;
                                word_send_data_d = rd_data;
                            end else begin
                                cmd_error_d      = 1'b1;
                                word_send_data_d = err_reply(opcode);
                            end
                        end
                        OP_STATUS: begin
                            word_send_data_d = {VERSION, 8'(NUM_REGS), err_field, 32'd0};
                        end
                        default: begin
                            cmd_error_d      = 1'b1;
                            word_send_data_d = err_reply(opcode);
                        end
                    endcase
                end
                ST_WR_PAYLOAD: begin
                    // Payload is stored whole; its top byte is not an opcode.
                    reg_wr_en        = 1'b1;
                    cfg_wr_stb_d     = 1'b1;
                    cfg_wr_addr_d    = addr_q;
                    word_send_data_d = word_data_received;
                    state_d          = ST_IDLE;
                end
                ST_RD_DUMMY: begin
                    word_send_data_d = 64'd0;
                    state_d          = ST_IDLE;
                end
                default: begin
                    word_send_data_d = 64'd0;
                    state_d          = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Register file next value: single write port at the latched address.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_wr_en && (addr_q == 8'(i))) begin
                regs_d[i] = word_data_received;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // FSM state, registered outputs and register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            addr_q           <= 8'd0;
            word_send_data_q <= 64'd0;
            cfg_wr_stb_q     <= 1'b0;
            cfg_wr_addr_q    <= 8'd0;
            cmd_error_q      <= 1'b0;
            busy_q           <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 64'd0;
            end
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            word_send_data_q <= word_send_data_d;
            cfg_wr_stb_q     <= cfg_wr_stb_d;
            cfg_wr_addr_q    <= cfg_wr_addr_d;
            cmd_error_q      <= cmd_error_d;
            busy_q           <= busy_d;
            regs_q           <= regs_d;
        end
    end

`ifdef CMD_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Saturating count of rejected commands.
    always_comb begin
        if (cmd_error_d && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_field = err_count_q;
`else
    assign err_field = 16'd0;
`endif

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg_flat
        assign cfg_regs[64*gi +: 64] = regs_q[gi];
    end

    assign word_send_data = word_send_data_q;
    assign cfg_wr_stb     = cfg_wr_stb_q;
    assign cfg_wr_addr    = cfg_wr_addr_q;
    assign cmd_error      = cmd_error_q;
    assign busy           = busy_q;

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter NUM_REGS, default 8, number of 64-bit configuration registers (1..256).
REQ-002 Parameter VERSION, default 8'h01, 8-bit constant reported by STATUS.
REQ-003 clk  input  1  system clock, the same clock as the SPI word receiver; one clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 word_received  input  1  level from the upstream SPI word receiver, high while a complete 64-bit word is held.
REQ-006 word_data_received  input  64  last received word; bits [63:56] opcode, [7:0] address.
REQ-007 word_send_data  output  64  reply word handed to the upstream SPI word transmitter.
REQ-008 cfg_regs  output  64*NUM_REGS  flattened register file; reg i occupies bits [64*i+63:64*i].
REQ-009 cfg_wr_stb  output  1  one-cycle pulse when a register write commits.
REQ-010 cfg_wr_addr  output  8  address of the last committed write.
REQ-011 cmd_error  output  1  one-cycle pulse on a rejected command.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 word strobe = word_received & ~word_received_q (registered copy); exactly one strobe per received word, even if word_received stays high for many cycles.
REQ-014 States: IDLE, WR_PAYLOAD, RD_DUMMY; every transition occurs only on a strobe.
REQ-015 IDLE, opcode 8'h00 NOP: word_send_data <= 0; stay IDLE.
REQ-016 IDLE, opcode 8'h01 WRITE: latch addr; go to WR_PAYLOAD; word_send_data <= {8'hA1, 48'd0, addr}.
REQ-017 WR_PAYLOAD strobe: reg[addr] <= word; cfg_wr_stb=1 and cfg_wr_addr=addr in the next cycle; word_send_data <= word (echo); go to IDLE.
REQ-018 IDLE, opcode 8'h02 READ: word_send_data <= reg[addr]; go to RD_DUMMY; the next strobe returns to IDLE, ignores its data, and sets word_send_data <= 0.
REQ-019 IDLE, opcode 8'h03 STATUS: word_send_data <= {VERSION, 8'(NUM_REGS), 16'(err_count), 32'd0}; stay IDLE.
REQ-020 Unknown opcode, or WRITE/READ with addr >= NUM_REGS: cmd_error pulse; word_send_data <= {8'hEE, 48'd0, opcode}; stay IDLE; register file unchanged.
REQ-021 Latency: word_send_data, cfg_regs, cfg_wr_stb and cmd_error update exactly 1 clk after the strobe cycle.
REQ-022 A write and a read of the same register cannot overlap, since commands are serialized by the FSM; reads see the value of the last committed write.
REQ-023 Opcode bits of payload and dummy words are never decoded.

Reset
REQ-024 During reset: state=IDLE, all cfg_regs=0, word_send_data=0, cfg_wr_stb=0, cfg_wr_addr=0, cmd_error=0, busy=0, err_count=0, word_received_q=0.
REQ-025 Reset mid-command aborts the command with no register write; if word_received is high when reset releases, no strobe is generated until it falls and rises again.

Configuration
REQ-026 Macro CMD_ERR_COUNT_EN defined: 16-bit err_count increments on each cmd_error pulse, saturates at 16'hFFFF, and is reported by STATUS.
REQ-027 Macro absent: no counter is implemented and the STATUS err field reads 16'd0.

Structure
REQ-028 Package spi_cmd_pkg holds the opcode constants (NOP, WRITE, READ, STATUS), the reply tags 8'hA1 and 8'hEE, and the state enum.
REQ-029 Sub-module spi_cmd_edge implements the word_received rising-edge strobe; the register file stays inline.

Verification
REQ-030 Stimulus: WRITE addr 3, then payload 64'hDEADBEEF_01234567 -> cfg_regs[3] equals the payload, cfg_wr_stb pulses once with cfg_wr_addr=3, and the echo appears in word_send_data.
REQ-031 Stimulus: READ addr 3 after REQ-030 -> word_send_data = 64'hDEADBEEF_01234567; the dummy word returns to IDLE and word_send_data becomes 0.
REQ-032 Stimulus: opcode 8'h7F, then WRITE addr 8 -> two cmd_error pulses and no register changes; with the macro, STATUS reports err=2; without it, err=0.
REQ-033 Stimulus: word_received held high for 20 cycles -> exactly one strobe and one command executed.
REQ-034 Stimulus: WRITE addr 1, then reset asserted before the payload -> IDLE with cfg_regs[1]=0; the next strobed word is decoded as a new command.
